// File: rtl/ff_goodness_unit_if.sv
// Goodness unit port bundle: membrane beats from the SNN cores in,
// per-sample goodness and class averages out.
interface ff_goodness_unit_if #(
  parameter int CORE_NUM            = 1,
  parameter int POST_NEUR_PARALLEL  = 8,
  parameter int POST_NEUR_MEM_WIDTH = 13,
  parameter int GOODNESS_WIDTH      = 20
);

  localparam int BUS_W =
    CORE_NUM * POST_NEUR_PARALLEL * POST_NEUR_MEM_WIDTH;

  logic [CORE_NUM-1:0]       CORE_VALID;
  logic [BUS_W-1:0]          CORE_MEM_BUS;
  logic                      CORE_CLEAR;
  logic                      IS_POS;
  logic                      IS_TRAIN;
  logic [GOODNESS_WIDTH-1:0] SAMPLE_GOODNESS;
  logic                      SAMPLE_VALID;
  logic [GOODNESS_WIDTH-1:0] POS_AVG;
  logic [GOODNESS_WIDTH-1:0] NEG_AVG;
  logic [GOODNESS_WIDTH-1:0] AVG_GOODNESS;
  logic                      BUSY;
  logic                      ERR_OVF;

  modport master (
    output CORE_VALID,
    output CORE_MEM_BUS,
    output CORE_CLEAR,
    output IS_POS,
    output IS_TRAIN,
    input  SAMPLE_GOODNESS,
    input  SAMPLE_VALID,
    input  POS_AVG,
    input  NEG_AVG,
    input  AVG_GOODNESS,
    input  BUSY,
    input  ERR_OVF
  );

  modport slave (
    input  CORE_VALID,
    input  CORE_MEM_BUS,
    input  CORE_CLEAR,
    input  IS_POS,
    input  IS_TRAIN,
    output SAMPLE_GOODNESS,
    output SAMPLE_VALID,
    output POS_AVG,
    output NEG_AVG,
    output AVG_GOODNESS,
    output BUSY,
    output ERR_OVF
  );

endinterface

// File: rtl/ff_goodness_unit.sv
// Forward-forward goodness: sums rectified membrane lanes per sample,
// averages per beat and tracks EMA goodness per class plus a threshold.
module ff_goodness_unit #(
  parameter int CORE_NUM            = 1,
  parameter int POST_NEUR_PARALLEL  = 8,
  parameter int POST_NEUR_MEM_WIDTH = 13,
  parameter int GOODNESS_WIDTH      = 20,
  parameter int ACC_BEATS           = 32,
  parameter int EMA_SHIFT           = 3
) (
  input logic              CLK,
  input logic              RST,
  ff_goodness_unit_if.slave bus
);

  localparam int GW    = GOODNESS_WIDTH;
  localparam int PAR   = POST_NEUR_PARALLEL;
  localparam int MW    = POST_NEUR_MEM_WIDTH;
  localparam int LANES = CORE_NUM * PAR;
  localparam int SUMW  = MW + $clog2(LANES + 1);
  localparam int EW    = ((GW > SUMW) ? GW : SUMW) + 1;
  localparam int CW    = $clog2(ACC_BEATS + 1);
  localparam int SH    = $clog2(ACC_BEATS);

  localparam logic [CW-1:0] BEATS = CW'(ACC_BEATS);
  localparam logic [EW-1:0] ACC_MAX =
    {{(EW-GW){1'b0}}, {GW{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    UPDATE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [GW-1:0]       acc;
  logic [CW-1:0]       cnt [CORE_NUM];
  logic [CORE_NUM-1:0] take;
  logic [EW-1:0]       beat_sum;
  logic [EW-1:0]       acc_sum;
  logic                acc_ovf;
  logic                all_done;

  logic          lbl_pos;
  logic          lbl_train;
  logic          pos_init;
  logic          neg_init;
  logic [GW-1:0] goodness;
  logic [GW-1:0] pos_avg;
  logic [GW-1:0] neg_avg;
  logic [GW-1:0] avg_good;
  logic [GW-1:0] avg_nxt;
  logic [GW:0]   avg_pair;
  logic [GW-1:0] g_new;
  logic          smp_valid;
  logic          ovf;

  function automatic logic [GW-1:0] ema(
    input logic [GW-1:0] avg,
    input logic [GW-1:0] g
  );
    logic signed [GW:0] d;
    logic signed [GW:0] s;
    d = $signed({1'b0, g}) - $signed({1'b0, avg});
    s = $signed({1'b0, avg}) + (d >>> EMA_SHIFT);
    return GW'(s);
  endfunction

  // Beats riding with CLEAR are the first beats of the new sample.
  always_comb begin
    beat_sum = '0;
    take     = '0;
    for (int c = 0; c < CORE_NUM; c++) begin
      take[c] = bus.CORE_VALID[c] &
                (bus.CORE_CLEAR |
                 ((state == ACC) && (cnt[c] < BEATS)));
      if (take[c]) begin
        for (int l = 0; l < PAR; l++) begin
          if (!bus.CORE_MEM_BUS[(c*PAR+l)*MW + MW-1]) begin
            beat_sum = beat_sum +
              EW'(bus.CORE_MEM_BUS[(c*PAR+l)*MW +: MW]);
          end
        end
      end
    end
  end

  always_comb begin
    acc_sum = (bus.CORE_CLEAR ? '0 : EW'(acc)) + beat_sum;
    acc_ovf = acc_sum > ACC_MAX;
  end

  always_comb begin
    all_done = 1'b1;
    for (int c = 0; c < CORE_NUM; c++) begin
      if (cnt[c] != BEATS) all_done = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.CORE_CLEAR) begin
      state_nxt = ACC;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        ACC:     if (all_done) state_nxt = UPDATE;
        UPDATE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign g_new    = acc >> SH;
  assign avg_pair = {1'b0, pos_avg} + {1'b0, neg_avg};

  always_comb begin
    avg_nxt = '0;
    unique case ({pos_init, neg_init})
      2'b11:   avg_nxt = GW'(avg_pair >> 1);
      2'b10:   avg_nxt = pos_avg;
      2'b01:   avg_nxt = neg_avg;
      default: avg_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc       <= '0;
      for (int c = 0; c < CORE_NUM; c++) cnt[c] <= '0;
      lbl_pos   <= 1'b0;
      lbl_train <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (bus.CORE_CLEAR) begin
        lbl_pos   <= bus.IS_POS;
        lbl_train <= bus.IS_TRAIN;
      end
      if (bus.CORE_CLEAR || (state == ACC)) begin
        acc <= acc_ovf ? GW'(ACC_MAX) : GW'(acc_sum);
        if (acc_ovf) ovf <= 1'b1;
      end
      for (int c = 0; c < CORE_NUM; c++) begin
        if (bus.CORE_CLEAR)  cnt[c] <= CW'(take[c]);
        else if (take[c])    cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  // A CLEAR landing in UPDATE wins and the finished sample is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      smp_valid <= 1'b0;
      goodness  <= '0;
      pos_avg   <= '0;
      neg_avg   <= '0;
      pos_init  <= 1'b0;
      neg_init  <= 1'b0;
      avg_good  <= '0;
    end else begin
      smp_valid <= 1'b0;
      avg_good  <= avg_nxt;
      if ((state == UPDATE) && !bus.CORE_CLEAR) begin
        smp_valid <= 1'b1;
        goodness  <= g_new;
        if (lbl_train && lbl_pos) begin
          pos_avg  <= pos_init ? ema(pos_avg, g_new) : g_new;
          pos_init <= 1'b1;
        end
        if (lbl_train && !lbl_pos) begin
          neg_avg  <= neg_init ? ema(neg_avg, g_new) : g_new;
          neg_init <= 1'b1;
        end
      end
    end
  end

  assign bus.SAMPLE_GOODNESS = goodness;
  assign bus.SAMPLE_VALID    = smp_valid;
  assign bus.POS_AVG         = pos_avg;
  assign bus.NEG_AVG         = neg_avg;
  assign bus.AVG_GOODNESS    = avg_good;
  assign bus.BUSY            = (state != IDLE);
  assign bus.ERR_OVF         = ovf;

endmodule

// File: doc/ff_goodness_unit.md
FF_GOODNESS_UNIT -- requirements
Module: ff_goodness_unit

Interface
REQ-001 SHALL have parameter CORE_NUM, default 1: number of SNN cores feeding goodness.
REQ-002 SHALL have parameter POST_NEUR_PARALLEL, default 8: membrane lanes per core per beat.
REQ-003 SHALL have parameter POST_NEUR_MEM_WIDTH, default 13: signed two's-complement lane width.
REQ-004 SHALL have parameter GOODNESS_WIDTH, default 20: unsigned width of accumulator, goodness and averages.
REQ-005 SHALL have parameter ACC_BEATS, default 32: beats per core per sample; power of two, at least 2.
REQ-006 SHALL have parameter EMA_SHIFT, default 3: moving-average smoothing shift.
REQ-007 SHALL have port CLK, input, 1 bit: clock; all state changes on the rising edge.
REQ-008 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port CORE_VALID, input, CORE_NUM bits: per-core membrane beat valid.
REQ-010 SHALL have port CORE_MEM_BUS, input, CORE_NUM*POST_NEUR_PARALLEL*POST_NEUR_MEM_WIDTH bits: lanes; core c and lane l at slice index c*POST_NEUR_PARALLEL+l.
REQ-011 SHALL have port CORE_CLEAR, input, 1 bit: start a new sample.
REQ-012 SHALL have ports IS_POS and IS_TRAIN, inputs, 1 bit each: sample label and training mode, sampled when CORE_CLEAR is high.
REQ-013 SHALL have port SAMPLE_GOODNESS, output, GOODNESS_WIDTH bits: last completed sample goodness.
REQ-014 SHALL have port SAMPLE_VALID, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have ports POS_AVG, NEG_AVG and AVG_GOODNESS, outputs, GOODNESS_WIDTH bits each: running averages and threshold.
REQ-016 SHALL have port BUSY, output, 1 bit: high in ACC or UPDATE.
REQ-017 SHALL have port ERR_OVF, output, 1 bit: sticky accumulator saturation flag.

Function
REQ-018 SHALL implement states IDLE, ACC and UPDATE.
REQ-019 CORE_CLEAR in any state SHALL zero the accumulator and all per-core beat counters, latch IS_POS and IS_TRAIN, and enter ACC on the next edge; averages are left unchanged.
REQ-020 CORE_CLEAR in UPDATE SHALL discard that sample: no SAMPLE_VALID and no average update.
REQ-021 In IDLE, CORE_VALID without CORE_CLEAR SHALL be ignored.
REQ-022 A beat from core c SHALL be accepted in ACC when CORE_VALID[c]=1 and that core's count is below ACC_BEATS, or in the same cycle as CORE_CLEAR.
REQ-023 Beats accepted with CORE_CLEAR SHALL count as the first beats of the new sample.
REQ-024 Beats from a core whose count has reached ACC_BEATS SHALL be ignored.
REQ-025 Each accepted beat SHALL contribute the sum of its lanes, with negative lanes counted as 0.
REQ-026 All cores' accepted beats in one cycle SHALL be added to the accumulator in that cycle.
REQ-027 The accumulator SHALL saturate at 2^GOODNESS_WIDTH-1 and set ERR_OVF, which is cleared only by RST.
REQ-028 When every core count equals ACC_BEATS, the next edge SHALL enter UPDATE.
REQ-029 SAMPLE_VALID SHALL pulse one cycle on the edge leaving UPDATE, which returns to IDLE: 2 cycles after the last beat edge.
REQ-030 On that same edge SAMPLE_GOODNESS SHALL load acc >> log2(ACC_BEATS).
REQ-031 If the latched IS_TRAIN=1, the class average selected by the latched IS_POS (POS_AVG if 1, NEG_AVG if 0) SHALL update on that edge.
REQ-032 The first update after reset SHALL load the goodness g directly and set that class's init flag.
REQ-033 Later updates SHALL compute avg + ((g - avg) >>> EMA_SHIFT), using a signed (GOODNESS_WIDTH+1)-bit difference with arithmetic shift.
REQ-034 If the latched IS_TRAIN=0, POS_AVG and NEG_AVG SHALL hold.
REQ-035 AVG_GOODNESS SHALL be registered and updated one cycle after the averages.
REQ-036 AVG_GOODNESS SHALL be (POS_AVG+NEG_AVG)>>1 when both classes are initialised, the initialised class average when only one is, and 0 when neither is.

Reset
REQ-037 RST SHALL asynchronously force IDLE and zero the accumulator, counters, init flags, latched label and mode, and all outputs, including ERR_OVF and BUSY.
REQ-038 RST asserted mid-sample SHALL abort the sample without a SAMPLE_VALID pulse.

Verification
(Parameters: CORE_NUM=2, PAR=2, MEMW=8, GW=16, ACC_BEATS=4, EMA_SHIFT=2 unless stated.)
REQ-039 Bench SHALL cover: RST pulse during ACC -> all outputs 0 next cycle, BUSY=0, no SAMPLE_VALID.
REQ-040 Bench SHALL cover: CLEAR with IS_POS=1, IS_TRAIN=1, then 4 beats per core with all lanes +10 -> SAMPLE_GOODNESS=40 and SAMPLE_VALID 2 cycles after last beat; POS_AVG=40; AVG_GOODNESS=40 one cycle later.
REQ-041 Bench SHALL cover: a second positive sample with g=80 -> POS_AVG=50; then a negative sample with g=20 -> NEG_AVG=20 and AVG_GOODNESS=35.
REQ-042 Bench SHALL cover: lanes -5/+7 -> each beat contributes 7; staggered cores (core1 lagging 3 cycles) -> completion waits for core1; 5th core0 beat ignored.
REQ-043 Bench SHALL cover: CLEAR after 2 beats, then a full sample -> only one SAMPLE_VALID, goodness counts only post-CLEAR beats; a sample with IS_TRAIN=0 -> averages unchanged.
REQ-044 Bench SHALL cover: GW=10 with all lanes +127 -> accumulator 1023, SAMPLE_GOODNESS=255, ERR_OVF=1 held across a following CLEAR.
